lm32_ram_fifo: RTL and testbench
================================

LM32_RAM_FIFO -- requirements
Module: lm32_ram_fifo

Interface
REQ-001 Parameter data_width, default 32, width of each stored word.
REQ-002 Parameter addr_width, default 4, log2 of storage depth; depth D = 2^addr_width.
REQ-003 Parameter af_level, default D-2, level at or above which almost_full_o asserts; legal range 1..D.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 flush_i  input  1  discard all contents.
REQ-007 in_valid_i  input  1  write-side word offered.
REQ-008 in_data_i  input  data_width  write-side word.
REQ-009 in_ready_o  output  1  write side can accept.
REQ-010 out_valid_o  output  1  head word present on out_data_o.
REQ-011 out_data_o  output  data_width  head word.
REQ-012 out_ready_i  input  1  read side consumes head.
REQ-013 level_o  output  addr_width+1  number of stored words, 0..D.
REQ-014 almost_full_o  output  1  level_o >= af_level.

Function
REQ-015 Storage SHALL be a D x data_width memory with one write port and one read port whose read address is registered and whose data output is combinational from that registered address.
REQ-016 push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; handshakes complete on the rising edge.
REQ-017 in_ready_o SHALL equal (level_o != D) & ~flush_i, combinationally; no pass-through when full.
REQ-018 out_valid_o SHALL be registered and equal (level_o != 0); out_data_o is don't-care when out_valid_o is low.
REQ-019 On push, the memory SHALL write in_data_i at wptr, and wptr SHALL increment modulo D.
REQ-020 On pop, rptr SHALL increment modulo D; the read address register SHALL be loaded every cycle with the next-cycle rptr (rptr+pop), so out_data_o shows mem[rptr] with zero bubble.
REQ-021 Latency: a word pushed into an empty FIFO at edge t SHALL appear with out_valid_o high in the cycle after edge t.
REQ-022 Level update: push only -> +1; pop only -> -1; push and pop together -> unchanged, both pointers advance.
REQ-023 Simultaneous push and pop at level 1 SHALL present the new word as head in the next cycle with no gap in out_valid_o.
REQ-024 Pointer wrap-around from D-1 to 0 SHALL be seamless; words SHALL exit in strict push order.
REQ-025 almost_full_o SHALL be registered, updated from next-state level, and consistent with level_o every cycle.
REQ-026 flush_i SHALL override push and pop: at the edge, wptr, rptr, and the read address register go to 0, level_o goes to 0, and out_valid_o goes to 0; memory contents are not cleared.
REQ-027 out_ready_i while out_valid_o is low SHALL have no effect; there is no underflow state.

Reset
REQ-028 While rst_i is high at an edge: wptr=0, rptr=0, read address register=0, level_o=0, out_valid_o=0, almost_full_o=0.
REQ-029 Reset SHALL take priority over flush_i, push, and pop; in_ready_o follows REQ-017 from the reset state (high unless flush_i).
REQ-030 Reset mid-stream SHALL discard all held words; the first push after reset appears as head per REQ-021.

Verification
REQ-031 D=16: push 0x11,0x22,0x33 on consecutive cycles with out_ready_i=0 -> level_o 1,2,3; out_valid_o high from the cycle after the first push; out_data_o=0x11.
REQ-032 Fill to 16 -> in_ready_o=0, almost_full_o=1 from level 14, level_o=16; extra in_valid_i is not stored; then drain with out_ready_i=1 -> 16 words in order, out_valid_o falls after the last pop.
REQ-033 Level 1 (head 0xA5), simultaneous push 0x5A and pop -> level_o stays 1; next cycle out_data_o=0x5A, out_valid_o continuous.
REQ-034 Stream 40 words with random valid/ready throttling -> output order is identical to input, with no loss or duplication across pointer wraps.
REQ-035 Level 5, flush_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle level_o=0, out_valid_o=0, pushed word dropped; the next push appears as head.
REQ-036 Level 7, rst_i=1 for one cycle -> level_o=0, out_valid_o=0, almost_full_o=0; a push 0xC3 afterwards is presented with out_valid_o high one cycle later.

Source files
------------

// File: rtl/lm32_ram_fifo.sv
// Single-clock FIFO over a D-entry RAM with registered read address.
// Head word is visible combinationally from the read address register.
module lm32_ram_fifo #(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int af_level   = (1 << addr_width) - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [data_width-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [data_width-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [addr_width:0]   level_o,
    output logic                  almost_full_o
);

    localparam int D = 1 << addr_width;
    localparam logic [addr_width:0]   LVL_FULL = (addr_width + 1)'(D);
    localparam logic [addr_width:0]   LVL_AF   = (addr_width + 1)'(af_level);
    localparam logic [addr_width:0]   LVL_ONE  = (addr_width + 1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE  = addr_width'(1);

    logic [data_width-1:0] mem_q [D];

    logic [addr_width-1:0] wptr_q, wptr_d;
    logic [addr_width-1:0] rptr_q, rptr_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [addr_width:0]   level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic                  af_q, af_d;
    logic                  push, pop;

    assign in_ready_o = (level_q != LVL_FULL) & ~flush_i;
    assign push       = in_valid_i & in_ready_o;
    assign pop        = out_valid_q & out_ready_i & ~flush_i;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LVL_ONE;
            else if (pop && !push) level_d = level_q - LVL_ONE;
        end
        // Read address tracks next-cycle rptr so the head is ready with no bubble
        raddr_d     = rptr_d;
        out_valid_d = (level_d != '0);
        af_d        = (level_d >= LVL_AF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            raddr_q     <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            raddr_q     <= raddr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
        end
    end

    // Storage is not reset or cleared by flush
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wptr_q] <= in_data_i;
    end

    assign out_data_o    = mem_q[raddr_q];
    assign out_valid_o   = out_valid_q;
    assign level_o       = level_q;
    assign almost_full_o = af_q;

endmodule

// File: tb/tb_lm32_ram_fifo.sv
// Bench for lm32_ram_fifo: queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_lm32_ram_fifo;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int AF = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          iv = 1'b0;
    logic [DW-1:0] id = '0;
    logic          ordy = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          af;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int pushed = 0;

    logic [DW-1:0] q[$];

    lm32_ram_fifo #(
        .data_width(DW),
        .addr_width(AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (iv),
        .in_data_i    (id),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (ordy),
        .level_o      (level),
        .almost_full_o(af)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue of at most D words
    always @(posedge clk) begin
        bit p_in, p_out;
        p_in  = iv && (q.size() != D) && !flush;
        p_out = ordy && (q.size() != 0) && !flush;
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            if (p_out) void'(q.pop_front());
            if (p_in) begin
                q.push_back(id);
                pushed++;
            end
        end
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", DW'(level), DW'(q.size()));
            chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
            chk("almost_full", DW'(af), DW'(q.size() >= AF));
            chk("in_ready", DW'(in_ready), DW'((q.size() != D) && !flush));
            if (q.size() != 0) chk("head", out_data, q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        iv = 1'b1;
        id = d;
        step();
        iv = 1'b0;
    endtask

    task automatic drain(input int n);
        ordy = 1'b1;
        repeat (n) step();
        ordy = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_level", DW'(level), 0);
        chk("rst_valid", DW'(out_valid), 0);
        chk("rst_ready", DW'(in_ready), 1);
        chk("rst_af", DW'(af), 0);

        // three pushes, no reads
        push1(32'h11);
        @(negedge clk);
        chk("lvl1", DW'(level), 1);
        chk("valid_after_first", DW'(out_valid), 1);
        push1(32'h22);
        push1(32'h33);
        @(negedge clk);
        chk("lvl3", DW'(level), 3);
        chk("head_11", out_data, 32'h11);

        // fill to 16 and offer two more
        for (int i = 3; i < 18; i++) push1(32'h100 + DW'(i));
        @(negedge clk);
        chk("full_level", DW'(level), 16);
        chk("full_ready", DW'(in_ready), 0);
        chk("full_af", DW'(af), 1);
        drain(16);
        @(negedge clk);
        chk("drained_valid", DW'(out_valid), 0);
        chk("drained_level", DW'(level), 0);

        // simultaneous push/pop at level 1
        push1(32'hA5);
        iv = 1'b1;
        id = 32'h5A;
        ordy = 1'b1;
        step();
        iv = 1'b0;
        ordy = 1'b0;
        @(negedge clk);
        chk("pp_level", DW'(level), 1);
        chk("pp_head", out_data, 32'h5A);
        chk("pp_valid", DW'(out_valid), 1);
        drain(1);

        // throttled stream across pointer wraps
        pushed = 0;
        cyc = 0;
        while (pushed < 40 && cyc < 400) begin
            iv = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 2) != 0);
            id = 32'hC000 + DW'(pushed);
            step();
            cyc++;
        end
        iv = 1'b0;
        chk("stream_count", DW'(pushed), 40);
        drain(20);
        @(negedge clk);
        chk("stream_empty", DW'(level), 0);

        // flush at level 5 overrides push and pop
        for (int i = 0; i < 5; i++) push1(32'h500 + DW'(i));
        flush = 1'b1;
        iv = 1'b1;
        id = 32'hDEAD;
        ordy = 1'b1;
        step();
        flush = 1'b0;
        iv = 1'b0;
        ordy = 1'b0;
        @(negedge clk);
        chk("flush_level", DW'(level), 0);
        chk("flush_valid", DW'(out_valid), 0);
        push1(32'h77);
        @(negedge clk);
        chk("post_flush_head", out_data, 32'h77);
        chk("post_flush_valid", DW'(out_valid), 1);
        drain(1);

        // reset mid-stream at level 7
        for (int i = 0; i < 7; i++) push1(32'h700 + DW'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", DW'(level), 0);
        chk("mid_rst_valid", DW'(out_valid), 0);
        chk("mid_rst_af", DW'(af), 0);
        push1(32'hC3);
        @(negedge clk);
        chk("post_rst_head", out_data, 32'hC3);
        chk("post_rst_valid", DW'(out_valid), 1);
        drain(2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
